shift_unit: RTL and testbench
=============================

# shift_unit

Multi-cycle 32-bit shift register for the datapath. It loads its operand from the shift-entry select path (B, A or sign-extended immediate shifted left 2) and then performs logical, arithmetic or (optionally) rotate shifts, one bit position per clock. The FSM drives it with a start/busy/done handshake and reads the result back into the register file write-data path.

## Interface
Parameters:
- WIDTH, 32, data width; must be 32 in this datapath
- NBITS, 5, shift-amount width, equal to log2(WIDTH)

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only while busy=0
- op  in  3  command: 000 nop, 001 load, 010 sll, 011 srl, 100 sra, 101 rotr, 110 rotl, 111 reserved
- entry  in  WIDTH  operand from the shift-entry select path, used only by load
- n  in  NBITS  shift amount, sampled with start
- out  out  WIDTH  shift register contents
- busy  out  1  command in progress
- done  out  1  one-cycle pulse, command complete

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, op=load: out <= entry, go to DONE.
- IDLE, start=1, shift op, n>0: latch op, cnt <= n, go to SHIFT. out is unchanged on this edge.
- IDLE, start=1, shift op, n=0: go to DONE. out is unchanged.
- IDLE, start=1, nop/reserved: go to DONE with no data change.
- SHIFT, each edge:
  - out shifts by exactly 1 position and cnt decrements.
  - sll: {out[30:0],0}; srl: {0,out[31:1]}; sra: {out[31],out[31:1]}.
  - rotr: {out[0],out[31:1]}; rotl: {out[30:0],out[31]}.
  - When cnt=1 on the edge, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. Next state is IDLE, or it accepts a new start in that same cycle exactly as IDLE does.
- Shift ops act on the current out value; entry is ignored by them. A shift after a load operates on the loaded value.
- start, op and n while busy=1 are ignored; there is no queueing.
- out holds its value in IDLE and DONE.

## Timing
- Reset values: out=0, busy=0, done=0, state IDLE, cnt=0.
- Reset mid-command aborts immediately on that edge. No done pulse is issued.
- start sampled at edge E.
  - load/nop/n=0: done=1 and final out visible in cycle E+1.
  - shift by k≥1: busy=1 in cycles E+1..E+k; out takes intermediate values after each of edges E+1..E+k; done=1 with final out in cycle E+k+1; busy=0 from cycle E+k+1.
- Latency: 1 cycle for load, nop and n=0; k+1 cycles for a shift by k.
- A start in the done cycle is accepted, giving back-to-back commands with no idle bubble.
- busy and done are never both 1 in the same cycle.
- Max shift is 31 (n is 5 bits); bits shifted out are lost except for rotates.

## Configuration
- SHIFT_ROTATE_EN defined: rotr (101) and rotl (110) are implemented as described.
- SHIFT_ROTATE_EN undefined: 101 and 110 are decoded as reserved.
  - They behave as nop: done after 1 cycle, out unchanged, no SHIFT state.
  - The rotate datapath is absent.

## Test plan
- Reset, then load entry=0x8000_00F0 -> out=0x8000_00F0 and done=1 one cycle after start; busy never 1.
- After that load, sra n=4 -> busy for 4 cycles, out=0xF800_000F with done on cycle 5; then srl n=4 from 0x8000_00F0 gives 0x0800_000F.
- sll n=31 on 0x0000_0003 -> out=0x8000_0000 after 32 cycles; start pulses with other ops during busy are ignored.
- sll n=0 on 0x1234_5678 -> done in 1 cycle, out unchanged; back-to-back start in the done cycle with load 0xDEAD_BEEF -> accepted, out=0xDEAD_BEEF one cycle later.
- With SHIFT_ROTATE_EN: rotr n=8 on 0x1234_5678 -> 0x7812_3456 after 8 shift cycles. Without it: the same command gives done in 1 cycle, out=0x1234_5678.
- reset asserted at cycle 3 of an sll n=10 -> next cycle out=0, busy=0, done=0, no done pulse; a new load is accepted normally afterwards.

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle shift register: loads an operand, then shifts one bit position per clock.
// Optional rotate support (rotr/rotl) is enabled by defining SHIFT_ROTATE_EN.
module shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] entry,
    input  logic [NBITS-1:0] n,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SLL  = 3'b010;
    localparam logic [2:0] OP_SRL  = 3'b011;
    localparam logic [2:0] OP_SRA  = 3'b100;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] OP_ROTR = 3'b101;
    localparam logic [2:0] OP_ROTL = 3'b110;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [NBITS-1:0] cnt;
    logic [NBITS-1:0] cnt_nxt;
    logic [2:0]       op_q;
    logic [2:0]       op_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic [WIDTH-1:0] shifted_c;

    // Commands that enter the SHIFT state; everything else but load completes as a nop.
    function automatic logic is_shift(input logic [2:0] o);
        logic r;
        r = 1'b0;
        case (o)
            OP_SLL, OP_SRL, OP_SRA: r = 1'b1;
`ifdef SHIFT_ROTATE_EN
            OP_ROTR, OP_ROTL:       r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // One-position shift of the current contents using the latched op.
    always_comb begin
        shifted_c = out;
        case (op_q)
            OP_SLL:  shifted_c = {out[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted_c = {1'b0, out[WIDTH-1:1]};
            OP_SRA:  shifted_c = {out[WIDTH-1], out[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
            OP_ROTR: shifted_c = {out[0], out[WIDTH-1:1]};
            OP_ROTL: shifted_c = {out[WIDTH-2:0], out[WIDTH-1]};
`endif
            default: shifted_c = out;
        endcase
    end

    // Next-state and datapath control; DONE accepts a new command exactly like IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        out_nxt   = out;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    if (op == OP_LOAD) begin
                        out_nxt   = entry;
                        state_nxt = DONE;
                    end else if (is_shift(op) && (n != '0)) begin
                        op_nxt    = op;
                        cnt_nxt   = n;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                out_nxt = shifted_c;
                cnt_nxt = cnt - NBITS'(1);
                if (cnt == NBITS'(1)) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_NOP;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            out   <= out_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit; expected results are queued at command issue.
module tb_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] entry;
    logic [4:0]  n;
    logic [31:0] out;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    logic [31:0] mdl;
    logic [31:0] exp_out_q[$];
    int          exp_lat_q[$];

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    shift_unit #(.WIDTH(32), .NBITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .entry (entry),
        .n     (n),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command and queue its expected result and latency from the reference model.
    task automatic drive(input logic [2:0] o, input logic [31:0] e, input logic [4:0] k);
        logic [31:0] nm;
        int          lat;
        int          kk;
        kk  = int'(k);
        nm  = mdl;
        lat = 1;
        case (o)
            3'b001: nm = e;
            3'b010: begin nm = mdl << kk; lat = kk + 1; end
            3'b011: begin nm = mdl >> kk; lat = kk + 1; end
            3'b100: begin nm = 32'($signed(mdl) >>> kk); lat = kk + 1; end
            3'b101: if (ROT) begin
                nm  = (kk == 0) ? mdl : ((mdl >> kk) | (mdl << (32 - kk)));
                lat = kk + 1;
            end
            3'b110: if (ROT) begin
                nm  = (kk == 0) ? mdl : ((mdl << kk) | (mdl >> (32 - kk)));
                lat = kk + 1;
            end
            default: nm = mdl;
        endcase
        mdl = nm;
        exp_out_q.push_back(nm);
        exp_lat_q.push_back(lat);
        start = 1'b1;
        op    = o;
        entry = e;
        n     = k;
    endtask

    // Let the driven command be sampled, then wait for done and score it; returns in the done cycle.
    task automatic run(input bit noise, input string name);
        logic [31:0] eo;
        int          el;
        int          lat;
        bit          got;
        eo  = exp_out_q.pop_front();
        el  = exp_lat_q.pop_front();
        got = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            checks++;
            if ((busy & done) !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_done_overlap cycle %0d: busy=%b done=%b required not both 1", name, c, busy, done);
            end
            if (done === 1'b1) begin
                got = 1'b1;
                lat = c;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: got %b required 1", name, c, busy);
                end
                if (noise) begin
                    start = 1'b1;
                    op    = 3'b001;
                    entry = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles, required latency %0d", name, el);
        end else begin
            if (lat !== el) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", name, lat, el);
            end
            checks++;
            if (out !== eo) begin
                errors++;
                $display("FAIL %s out: got %h required %h", name, out, eo);
            end
        end
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out, busy, done} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: out=%h busy=%b done=%b required 0/0/0", out, busy, done);
        end
        reset = 1'b0;
        mdl   = 32'd0;
        idle_cycle();
    endtask

    task automatic test_load();
        drive(3'b001, 32'h8000_00F0, 5'd0);
        run(1'b0, "load");
        idle_cycle();
    endtask

    task automatic test_arith();
        drive(3'b100, 32'hFFFF_FFFF, 5'd4);
        run(1'b0, "sra4");
        drive(3'b001, 32'h8000_00F0, 5'd0);
        run(1'b0, "reload");
        drive(3'b011, 32'h0, 5'd4);
        run(1'b0, "srl4");
        idle_cycle();
    endtask

    task automatic test_sll_full();
        drive(3'b001, 32'h0000_0003, 5'd0);
        run(1'b0, "load3");
        drive(3'b010, 32'h0, 5'd31);
        run(1'b1, "sll31_noise");
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        drive(3'b001, 32'h1234_5678, 5'd0);
        run(1'b0, "load_1234");
        drive(3'b010, 32'h0, 5'd0);
        run(1'b0, "sll0");
        drive(3'b001, 32'hDEAD_BEEF, 5'd0);
        run(1'b0, "b2b_load");
        drive(3'b000, 32'h0, 5'd7);
        run(1'b0, "nop");
        drive(3'b111, 32'h5555_5555, 5'd9);
        run(1'b0, "reserved");
        idle_cycle();
    endtask

    task automatic test_rotate();
        drive(3'b001, 32'h1234_5678, 5'd0);
        run(1'b0, "load_rot");
        drive(3'b101, 32'h0, 5'd8);
        run(1'b0, "rotr8");
        drive(3'b110, 32'h0, 5'd4);
        run(1'b0, "rotl4");
        idle_cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            drive(3'b001, $urandom, 5'd0);
            run(1'b0, "rnd_load");
            drive(3'($urandom_range(2, 6)), $urandom, 5'($urandom_range(0, 31)));
            run(1'b0, "rnd_shift");
        end
        idle_cycle();
    endtask

    task automatic test_reset_abort();
        drive(3'b001, 32'h0000_0001, 5'd0);
        run(1'b0, "load_pre_abort");
        start = 1'b1;
        op    = 3'b010;
        n     = 5'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out, busy, done} !== 34'd0) begin
            errors++;
            $display("FAIL abort_state: out=%h busy=%b done=%b required 0/0/0", out, busy, done);
        end
        reset = 1'b0;
        mdl   = 32'd0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            checks++;
            if ((done !== 1'b0) || (busy !== 1'b0)) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: done=%b busy=%b required 0/0", c, done, busy);
            end
        end
        drive(3'b001, 32'hA5A5_5A5A, 5'd0);
        run(1'b0, "load_post_abort");
        drive(3'b011, 32'h0, 5'd3);
        run(1'b0, "srl_post_abort");
        idle_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mdl    = 32'd0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        entry  = 32'd0;
        n      = 5'd0;
        test_reset();
        test_load();
        test_arith();
        test_sll_full();
        test_back_to_back();
        test_rotate();
        test_random();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
